// File: rtl/fixed_accum_sat_if.sv
// fixed_accum_sat_if
//   Bundles the run handshake and the fixed-point sample stream of
//   fixed_accum_sat.
//   slave  : the accumulator side (drives o_* signals)
//   master : the requester / sample source side (drives i_* signals)
//   Run handshake : i_run_req, i_run_count, i_run_shift,
//                   o_run_busy, o_run_return, o_run_done, o_run_sat
//   Sample stream : i_fix_valid, i_fix_data, o_fix_ready
interface fixed_accum_sat_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int SH_W   = 5
);
  logic              i_run_req;
  logic [CNT_W-1:0]  i_run_count;
  logic [SH_W-1:0]   i_run_shift;
  logic              o_run_busy;
  logic [DATA_W-1:0] o_run_return;
  logic              o_run_done;
  logic              o_run_sat;
  logic              i_fix_valid;
  logic [DATA_W-1:0] i_fix_data;
  logic              o_fix_ready;

  modport slave (
    input  i_run_req, i_run_count, i_run_shift, i_fix_valid, i_fix_data,
    output o_run_busy, o_run_return, o_run_done, o_run_sat, o_fix_ready
  );

  modport master (
    output i_run_req, i_run_count, i_run_shift, i_fix_valid, i_fix_data,
    input  o_run_busy, o_run_return, o_run_done, o_run_sat, o_fix_ready
  );
endinterface

// File: rtl/fixed_accum_sat.sv
// fixed_accum_sat
//   Accumulates a requested number of signed fixed-point samples in a
//   widened accumulator, arithmetic-right-shifts the sum, saturates it to
//   DATA_W and returns it on the run handshake.
// Ports
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   ce    : clock enable; every register holds while low
//   bus   : fixed_accum_sat_if.slave (run handshake + sample stream)
//
// state  | meaning
// IDLE   | waiting for i_run_req; count/shift latched on accept
// ACC    | accepting samples until count have been summed
// SHIFT  | shift the sum, compute clipped value and saturation flag
// DONE   | load result outputs, pulse o_run_done, drop busy
module fixed_accum_sat #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int SH_W   = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ce,
  fixed_accum_sat_if.slave bus
);
  localparam int ACC_W = DATA_W + CNT_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         n_q;
  logic [SH_W-1:0]          sh_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        clip_q;
  logic [DATA_W-1:0]        clip_d;
  logic                     sat_q;
  logic                     sat_d;
  logic [DATA_W-1:0]        ret_q;
  logic                     ret_sat_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     accept;
  logic                     last;

  assign bus.o_fix_ready  = (state == S_ACC) & ce;
  assign bus.o_run_busy   = busy_q;
  assign bus.o_run_return = ret_q;
  assign bus.o_run_done   = done_q;
  assign bus.o_run_sat    = ret_sat_q;

  assign accept = bus.i_fix_valid & bus.o_fix_ready;
  assign last   = (n_q + CNT_W'(1)) == cnt_q;

  always_comb begin
    shifted = acc_q >>> sh_q;
    // The shifted sum fits in DATA_W only if every bit from the result MSB
    // upward is a copy of the sign bit.
    sat_d = shifted[ACC_W-1:DATA_W-1] != {(CNT_W+1){shifted[ACC_W-1]}};
    if (!sat_d)
      clip_d = shifted[DATA_W-1:0];
    else if (shifted[ACC_W-1])
      clip_d = {1'b1, {(DATA_W-1){1'b0}}};
    else
      clip_d = {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      clip_q    <= '0;
      sat_q     <= 1'b0;
      ret_q     <= '0;
      ret_sat_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (ce) begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_run_req) begin
            cnt_q  <= bus.i_run_count;
            sh_q   <= bus.i_run_shift;
            acc_q  <= '0;
            n_q    <= '0;
            busy_q <= 1'b1;
            state  <= (bus.i_run_count != '0) ? S_ACC : S_SHIFT;
          end
        end
        S_ACC: begin
          if (accept) begin
            acc_q <= acc_q + {{CNT_W{bus.i_fix_data[DATA_W-1]}}, bus.i_fix_data};
            n_q   <= n_q + CNT_W'(1);
            if (last)
              state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          clip_q <= clip_d;
          sat_q  <= sat_d;
          state  <= S_DONE;
        end
        S_DONE: begin
          ret_q     <= clip_q;
          ret_sat_q <= sat_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_accum_sat.sv
// tb_fixed_accum_sat
//   Scoreboard bench for fixed_accum_sat: the driver pushes the expected
//   result of each accepted run; a monitor pops and compares on every
//   o_run_done rising edge.
module tb_fixed_accum_sat;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int SH_W   = 5;

  logic clock = 1'b0;
  logic reset;
  logic ce;

  fixed_accum_sat_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SH_W(SH_W)) bus ();

  fixed_accum_sat #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SH_W(SH_W)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ret;
    logic        sat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] samp[256];
  bit          done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer sum, arithmetic shift, clamp to int32.
  function automatic exp_t model(input int cnt, input int sh);
    longint sum;
    longint s;
    exp_t   e;
    sum = 0;
    for (int i = 0; i < cnt; i++) sum += longint'($signed(samp[i]));
    s = sum >>> sh;
    if (s > 64'sd2147483647) begin
      e.ret = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      e.ret = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.ret = s[31:0]; e.sat = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.o_run_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got return 0x%0h, expected no result (t=%0t)",
                 bus.o_run_return, $time);
      end else begin
        e = exp_q.pop_front();
        check("return", bus.o_run_return, e.ret);
        check("sat", bus.o_run_sat, e.sat);
      end
    end
    done_prev = bus.o_run_done;
  end

  task automatic do_run(input int cnt, input int sh, input bit rnd,
                        input bit use_exp, input logic [31:0] eret, input bit esat);
    int   idx;
    int   budget;
    int   lat;
    exp_t e;
    idx = 0;
    @(negedge clock);
    ce = 1'b1;
    bus.i_run_req   = 1'b1;
    bus.i_run_count = cnt[7:0];
    bus.i_run_shift = sh[4:0];
    budget = 20;
    do begin
      @(negedge clock);
      budget--;
    end while (!bus.o_run_busy && budget > 0);
    check("req_accept_busy", bus.o_run_busy, 1);
    bus.i_run_req = 1'b0;
    if (use_exp) begin
      e.ret = eret; e.sat = esat;
    end else begin
      e = model(cnt, sh);
    end
    exp_q.push_back(e);
    budget = 3000;
    while (idx < cnt && budget > 0) begin
      @(negedge clock);
      ce              = rnd ? ($urandom_range(3) != 0) : 1'b1;
      bus.i_fix_valid = rnd ? ($urandom_range(2) != 0) : 1'b1;
      bus.i_fix_data  = bus.i_fix_valid ? samp[idx] : $urandom();
      #1;
      if (bus.i_fix_valid && bus.o_fix_ready) idx++;
      budget--;
    end
    check("samples_accepted", idx, cnt);
    ce = 1'b1;
    lat = 0;
    while (!bus.o_run_done && lat < 50) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        // junk outside ACC must be dropped
        bus.i_fix_valid = 1'b1;
        bus.i_fix_data  = $urandom();
      end
    end
    check("done_latency", lat, (cnt == 0) ? 2 : 3);
    check("busy_at_done", bus.o_run_busy, 0);
    @(negedge clock);
    bus.i_fix_valid = 1'b0;
    check("done_pulse_width", bus.o_run_done, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    int   cnt;
    int   m;
    reset = 1'b1;
    ce    = 1'b0;
    bus.i_run_req   = 1'b0;
    bus.i_run_count = '0;
    bus.i_run_shift = '0;
    bus.i_fix_valid = 1'b0;
    bus.i_fix_data  = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", bus.o_run_busy, 0);
    check("rst_return", bus.o_run_return, 0);
    check("rst_done", bus.o_run_done, 0);
    check("rst_sat", bus.o_run_sat, 0);
    check("rst_ready", bus.o_fix_ready, 0);
    reset = 1'b0;
    ce = 1'b1;

    // averaging of four samples
    for (int i = 0; i < 4; i++) samp[i] = 32'h0001_0000 * (i + 1);
    do_run(4, 2, 1'b0, 1'b1, 32'h0002_8000, 1'b0);

    // positive saturation and its shifted rerun
    samp[0] = 32'h7FFF_FFFF; samp[1] = 32'h7FFF_FFFF;
    do_run(2, 0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
    do_run(2, 1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0);

    // negative saturation, then a small negative sum
    for (int i = 0; i < 3; i++) samp[i] = 32'h8000_0000;
    do_run(3, 0, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
    samp[0] = 32'hFFFF_0000; samp[1] = 32'h0000_8000;
    do_run(2, 0, 1'b0, 1'b1, 32'hFFFF_8000, 1'b0);

    // async reset after two of four samples
    for (int i = 0; i < 4; i++) samp[i] = 32'h0001_0000 * (i + 1);
    @(negedge clock);
    bus.i_run_req = 1'b1; bus.i_run_count = 8'd4; bus.i_run_shift = 5'd0;
    @(negedge clock);
    bus.i_run_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.i_fix_valid = 1'b1;
      bus.i_fix_data  = samp[i];
      @(negedge clock);
    end
    bus.i_fix_valid = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_busy", bus.o_run_busy, 0);
    check("async_rst_return", bus.o_run_return, 0);
    check("async_rst_ready", bus.o_fix_ready, 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    samp[0] = 32'h0005_0000;
    do_run(1, 0, 1'b0, 1'b1, 32'h0005_0000, 1'b0);

    // zero count
    do_run(0, 7, 1'b0, 1'b1, 32'h0, 1'b0);

    // zero count with req held through the run: exactly one retake
    @(negedge clock);
    bus.i_run_req = 1'b1; bus.i_run_count = 8'd0; bus.i_run_shift = 5'd3;
    z.ret = 32'h0; z.sat = 1'b0;
    exp_q.push_back(z);
    exp_q.push_back(z);
    @(negedge clock); check("held_busy_1", bus.o_run_busy, 1);
    @(negedge clock); check("held_busy_2", bus.o_run_busy, 1);
    @(negedge clock); check("held_done", bus.o_run_done, 1);
    check("held_req_in_done_ignored", bus.o_run_busy, 0);
    @(negedge clock); check("held_retake", bus.o_run_busy, 1);
    bus.i_run_req = 1'b0;
    @(negedge clock);
    @(negedge clock); check("held_done_2", bus.o_run_done, 1);
    repeat (6) @(negedge clock);
    check("held_no_extra_run", bus.o_run_busy, 0);

    // ce gaps and valid gaps on the averaging case
    for (int i = 0; i < 4; i++) samp[i] = 32'h0001_0000 * (i + 1);
    do_run(4, 2, 1'b1, 1'b1, 32'h0002_8000, 1'b0);

    // randomized runs against the reference model
    repeat (40) begin
      cnt = ($urandom_range(9) == 0) ? 255 : int'($urandom_range(12));
      for (int i = 0; i < cnt; i++) begin
        m = int'($urandom_range(3));
        case (m)
          0: samp[i] = $urandom();
          1: samp[i] = $urandom_range(1) ? 32'h7FFF_FFFF : 32'h8000_0000;
          2: samp[i] = 32'(int'($urandom_range(511)) - 256);
          default: samp[i] = $urandom() >> $urandom_range(31);
        endcase
      end
      do_run(cnt, int'($urandom_range(31)), 1'b1, 1'b0, 32'h0, 1'b0);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
